// File: rtl/fir_tap_reader.sv
// FIR tap address sequencer: walks TAPS samples backwards from the newest sample,
// reads each with its coefficient, and emits registered sample/coefficient pairs.
module fir_tap_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int TAPS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              head_adv,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] smp_addr,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [DATA_W-1:0] smp_data,
    input  logic [DATA_W-1:0] coef_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_smp,
    output logic [DATA_W-1:0] out_coef,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_newest;
    logic [ADDR_W-1:0] r_idx;
    logic              r_rdEn;
    logic [ADDR_W-1:0] r_smpAddr;
    logic [ADDR_W-1:0] r_coefAddr;
    logic              r_rdEnD1;
    logic              r_lastD1;
    logic              r_outValid;
    logic              r_outLast;
    logic [DATA_W-1:0] r_outSmp;
    logic [DATA_W-1:0] r_outCoef;

    logic              w_lastIssue;
    logic [ADDR_W-1:0] w_nextIdx;

    assign w_lastIssue = (r_state == ISSUE) && (r_idx == LAST_IDX);
    assign w_nextIdx   = r_idx + 1'b1;

    // Address registers are loaded one cycle ahead so rd_en and both addresses
    // change together on the same edge the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wrPtr    <= '0;
            r_newest   <= '0;
            r_idx      <= '0;
            r_rdEn     <= 1'b0;
            r_smpAddr  <= '0;
            r_coefAddr <= '0;
            r_rdEnD1   <= 1'b0;
            r_lastD1   <= 1'b0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outSmp   <= '0;
            r_outCoef  <= '0;
        end else begin
            if (head_adv) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end

            r_rdEnD1 <= r_rdEn;
            r_lastD1 <= w_lastIssue;

            if (r_rdEnD1) begin
                r_outValid <= 1'b1;
                r_outLast  <= r_lastD1;
                r_outSmp   <= smp_data;
                r_outCoef  <= coef_data;
            end else begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_newest   <= r_wrPtr - 1'b1;
                        r_idx      <= '0;
                        r_rdEn     <= 1'b1;
                        r_smpAddr  <= r_wrPtr - 1'b1;
                        r_coefAddr <= '0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_idx == LAST_IDX) begin
                        r_rdEn  <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx      <= w_nextIdx;
                        r_smpAddr  <= r_newest - w_nextIdx;
                        r_coefAddr <= w_nextIdx;
                    end
                end
                DRAIN: begin
                    if (r_outValid && r_outLast) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr_ptr    = r_wrPtr;
    assign rd_en     = r_rdEn;
    assign smp_addr  = r_smpAddr;
    assign coef_addr = r_coefAddr;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign out_smp   = r_outSmp;
    assign out_coef  = r_outCoef;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_fir_tap_reader.sv
// Directed bench for fir_tap_reader: an 8-tap instance and a 1-tap instance share
// clock, reset, start and head_adv, each backed by a small synchronous memory model.
module tb_fir_tap_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        headAdv = 1'b0;

    logic [7:0]  wrPtr8, smpAddr8, coefAddr8;
    logic        rdEn8, outValid8, outLast8, busy8, done8;
    logic [15:0] smpData8, coefData8, outSmp8, outCoef8;

    logic [7:0]  wrPtr1, smpAddr1, coefAddr1;
    logic        rdEn1, outValid1, outLast1, busy1, done1;
    logic [15:0] smpData1, coefData1, outSmp1, outCoef1;

    int checks = 0;
    int fails  = 0;

    logic        capRd[0:31], capOv[0:31], capOl[0:31], capBusy[0:31], capDone[0:31];
    logic [7:0]  capSa[0:31], capCa[0:31];
    logic [15:0] capOs[0:31], capOc[0:31];
    logic        capRd1[0:31], capOv1[0:31], capOl1[0:31], capBusy1[0:31], capDone1[0:31];
    logic [7:0]  capSa1[0:31], capCa1[0:31];
    logic [15:0] capOs1[0:31], capOc1[0:31];

    always #5 clk = ~clk;

    function automatic logic [15:0] smpVal(input logic [7:0] a);
        return 16'h1000 + 16'(a) * 16'd3;
    endfunction

    function automatic logic [15:0] coefVal(input logic [7:0] a);
        return 16'h8000 - 16'(a) * 16'd5;
    endfunction

    // One-cycle-latency memories feeding each instance.
    always @(posedge clk) begin
        if (rdEn8 === 1'b1) begin
            smpData8  <= smpVal(smpAddr8);
            coefData8 <= coefVal(coefAddr8);
        end
        if (rdEn1 === 1'b1) begin
            smpData1  <= smpVal(smpAddr1);
            coefData1 <= coefVal(coefAddr1);
        end
    end

    fir_tap_reader #(.ADDR_W(8), .DATA_W(16), .TAPS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .head_adv(headAdv),
        .wr_ptr(wrPtr8), .rd_en(rdEn8), .smp_addr(smpAddr8), .coef_addr(coefAddr8),
        .smp_data(smpData8), .coef_data(coefData8), .out_valid(outValid8),
        .out_smp(outSmp8), .out_coef(outCoef8), .out_last(outLast8),
        .busy(busy8), .done(done8)
    );

    fir_tap_reader #(.ADDR_W(8), .DATA_W(16), .TAPS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .head_adv(headAdv),
        .wr_ptr(wrPtr1), .rd_en(rdEn1), .smp_addr(smpAddr1), .coef_addr(coefAddr1),
        .smp_data(smpData1), .coef_data(coefData1), .out_valid(outValid1),
        .out_smp(outSmp1), .out_coef(outCoef1), .out_last(outLast1),
        .busy(busy1), .done(done1)
    );

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseHead(input int n);
        headAdv = 1'b1;
        repeat (n) @(negedge clk);
        headAdv = 1'b0;
    endtask

    // Start cycle is the current one; capture index c is the c-th cycle after it.
    task automatic runPass(input int nCyc, input int againAt, input int headAt,
                           input int rstAt, input logic headWithStart);
        start   = 1'b1;
        headAdv = headWithStart;
        for (int c = 1; c <= nCyc; c++) begin
            @(negedge clk);
            start = 1'b0; headAdv = 1'b0; rst = 1'b0;
            capRd[c] = rdEn8; capSa[c] = smpAddr8; capCa[c] = coefAddr8;
            capOv[c] = outValid8; capOl[c] = outLast8; capOs[c] = outSmp8;
            capOc[c] = outCoef8; capBusy[c] = busy8; capDone[c] = done8;
            capRd1[c] = rdEn1; capSa1[c] = smpAddr1; capCa1[c] = coefAddr1;
            capOv1[c] = outValid1; capOl1[c] = outLast1; capOs1[c] = outSmp1;
            capOc1[c] = outCoef1; capBusy1[c] = busy1; capDone1[c] = done1;
            if (c == againAt) start = 1'b1;
            if (c == headAt) headAdv = 1'b1;
            if (c == rstAt) rst = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; headAdv = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wrPtr8, rdEn8, smpAddr8, coefAddr8, outValid8, outLast8, busy8, done8} !== 30'd0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl8 got wr=%0d rd=%b sa=%0d ca=%0d ov=%b ol=%b busy=%b done=%b, want all 0",
                     wrPtr8, rdEn8, smpAddr8, coefAddr8, outValid8, outLast8, busy8, done8);
        end
        checks++;
        if ({outSmp8, outCoef8} !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_data8 got smp=%h coef=%h, want 0", outSmp8, outCoef8);
        end
        checks++;
        if ({wrPtr1, rdEn1, busy1, done1, outValid1} !== 12'd0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl1 got wr=%0d rd=%b busy=%b done=%b ov=%b, want 0",
                     wrPtr1, rdEn1, busy1, done1, outValid1);
        end
        rst = 1'b0; headAdv = 1'b0;
        runPass(14, 0, 0, 0, 1'b0);
        checks++;
        if (capBusy[1] !== 1'b1 || capRd[1] !== 1'b1 || capSa[1] !== 8'd255) begin
            fails++;
            $display("[TB] FAIL start_after_reset got busy=%b rd=%b sa=%0d, want 1 1 255",
                     capBusy[1], capRd[1], capSa[1]);
        end
    endtask

    task automatic test_basic_pass();
        int smpList[8] = '{2, 1, 0, 255, 254, 253, 252, 251};
        logic [20:0] got, exp;
        pulseHead(3);
        checks++;
        if (wrPtr8 !== 8'd3) begin
            fails++;
            $display("[TB] FAIL basic_wrptr got %0d, want 3", wrPtr8);
        end
        runPass(12, 0, 0, 0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            got = {capRd[c], capSa[c], capCa[c], capOv[c], capOl[c], capBusy[c], capDone[c]};
            exp = {(c <= 8), (c <= 8) ? 8'(smpList[c-1]) : 8'd251, (c <= 8) ? 8'(c-1) : 8'd7,
                   (c >= 3 && c <= 10), (c == 10), (c <= 11), (c == 11)};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("[TB] FAIL basic_cycle%0d got %h, want %h (rd,sa,ca,ov,ol,busy,done)", c, got, exp);
            end
            if (c >= 3 && c <= 10) begin
                checks++;
                if (capOs[c] !== smpVal(8'(smpList[c-3])) || capOc[c] !== coefVal(8'(c-3))) begin
                    fails++;
                    $display("[TB] FAIL basic_data%0d got %h/%h, want %h/%h", c, capOs[c], capOc[c],
                             smpVal(8'(smpList[c-3])), coefVal(8'(c-3)));
                end
            end
        end
    endtask

    task automatic test_back_to_back_start_ignored();
        int nRd = 0, nOv = 0, nDone = 0, nLast = 0;
        runPass(18, 4, 0, 0, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            nRd += int'(capRd[c]); nOv += int'(capOv[c]);
            nDone += int'(capDone[c]); nLast += int'(capOl[c]);
        end
        checks++;
        if (nRd != 8 || nOv != 8 || nDone != 1 || nLast != 1) begin
            fails++;
            $display("[TB] FAIL start_ignored got rd=%0d ov=%0d done=%0d last=%0d, want 8 8 1 1",
                     nRd, nOv, nDone, nLast);
        end
        checks++;
        if (capDone[11] !== 1'b1 || capBusy[12] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL start_ignored_end got done11=%b busy12=%b, want 1 0", capDone[11], capBusy[12]);
        end
    endtask

    task automatic test_head_adv_during_pass();
        int smpList[8] = '{2, 1, 0, 255, 254, 253, 252, 251};
        runPass(12, 0, 3, 0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (capRd[c] !== 1'b1 || capSa[c] !== 8'(smpList[c-1]) || capCa[c] !== 8'(c-1)) begin
                fails++;
                $display("[TB] FAIL headadv_addr%0d got rd=%b sa=%0d ca=%0d, want 1 %0d %0d",
                         c, capRd[c], capSa[c], capCa[c], smpList[c-1], c-1);
            end
        end
        checks++;
        if (wrPtr8 !== 8'd4) begin
            fails++;
            $display("[TB] FAIL headadv_wrptr got %0d, want 4", wrPtr8);
        end
    endtask

    task automatic test_wrap();
        doReset();
        pulseHead(255);
        checks++;
        if (wrPtr8 !== 8'd255) begin
            fails++;
            $display("[TB] FAIL wrap_255 got %0d, want 255", wrPtr8);
        end
        pulseHead(1);
        checks++;
        if (wrPtr8 !== 8'd0 || wrPtr1 !== 8'd0) begin
            fails++;
            $display("[TB] FAIL wrap_zero got %0d/%0d, want 0/0", wrPtr8, wrPtr1);
        end
        runPass(12, 0, 0, 0, 1'b0);
        checks++;
        if (capSa[1] !== 8'd255 || capSa[2] !== 8'd254 || capCa[1] !== 8'd0) begin
            fails++;
            $display("[TB] FAIL wrap_addr got sa1=%0d sa2=%0d ca1=%0d, want 255 254 0",
                     capSa[1], capSa[2], capCa[1]);
        end
    endtask

    task automatic test_reset_mid_pass();
        int nOv = 0, nDone = 0;
        runPass(16, 0, 0, 5, 1'b0);
        checks++;
        if ({capRd[6], capSa[6], capCa[6], capOv[6], capOl[6], capBusy[6], capDone[6],
             capOs[6], capOc[6]} !== 53'd0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs got rd=%b sa=%0d ca=%0d ov=%b busy=%b done=%b smp=%h, want 0",
                     capRd[6], capSa[6], capCa[6], capOv[6], capBusy[6], capDone[6], capOs[6]);
        end
        for (int c = 6; c <= 16; c++) begin
            nOv += int'(capOv[c]); nDone += int'(capDone[c]);
        end
        checks++;
        if (nOv != 0 || nDone != 0 || wrPtr8 !== 8'd0) begin
            fails++;
            $display("[TB] FAIL midreset_quiet got ov=%0d done=%0d wr=%0d, want 0 0 0", nOv, nDone, wrPtr8);
        end
        nOv = 0;
        runPass(12, 0, 0, 0, 1'b0);
        for (int c = 1; c <= 12; c++) nOv += int'(capOv[c]);
        checks++;
        if (nOv != 8 || capOl[10] !== 1'b1 || capDone[11] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_repass got ov=%0d last10=%b done11=%b, want 8 1 1",
                     nOv, capOl[10], capDone[11]);
        end
    endtask

    task automatic test_taps1();
        int nOv = 0;
        doReset();
        pulseHead(5);
        runPass(6, 0, 0, 0, 1'b1);
        checks++;
        if (capRd1[1] !== 1'b1 || capSa1[1] !== 8'd4 || capCa1[1] !== 8'd0 || capRd1[2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL taps1_issue got rd1=%b sa=%0d ca=%0d rd2=%b, want 1 4 0 0",
                     capRd1[1], capSa1[1], capCa1[1], capRd1[2]);
        end
        for (int c = 1; c <= 6; c++) nOv += int'(capOv1[c]);
        checks++;
        if (nOv != 1 || capOv1[3] !== 1'b1 || capOl1[3] !== 1'b1 ||
            capOs1[3] !== smpVal(8'd4) || capOc1[3] !== coefVal(8'd0)) begin
            fails++;
            $display("[TB] FAIL taps1_out got n=%0d ov=%b last=%b data=%h/%h, want 1 1 1 %h/%h",
                     nOv, capOv1[3], capOl1[3], capOs1[3], capOc1[3], smpVal(8'd4), coefVal(8'd0));
        end
        checks++;
        if (capDone1[4] !== 1'b1 || capDone1[3] !== 1'b0 || capBusy1[5] !== 1'b0 || wrPtr1 !== 8'd6) begin
            fails++;
            $display("[TB] FAIL taps1_done got done3=%b done4=%b busy5=%b wr=%0d, want 0 1 0 6",
                     capDone1[3], capDone1[4], capBusy1[5], wrPtr1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_pass();
        test_back_to_back_start_ignored();
        test_head_adv_during_pass();
        test_wrap();
        test_reset_mid_pass();
        test_taps1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
